// File: rtl/sumator_pkg.sv
// Shared sizing for the 16-bit two-level carry-look-ahead adder.
package sumator_pkg;

  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [GROUP-1:0] nibble_t;

endpackage : sumator_pkg

// File: rtl/cla_bloc_4b.sv
// 4-bit carry-look-ahead block: look-ahead internal carries from cin,
// plus group generate/propagate for the second-level unit.
module cla_bloc_4b
  import sumator_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             G,
  output logic             P
);

  nibble_t g;
  nibble_t p;
  nibble_t c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum-of-products on cin; nothing ripples.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

endmodule : cla_bloc_4b

// File: rtl/sumator_cal_16b.sv
// 16-bit two-level CLA adder with registered Suma/C_out, latency 1.
// Define SUMATOR_OVF_EN to add the registered signed-overflow output Ovf.
module sumator_cal_16b
  import sumator_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] Suma,
  output logic             C_out
`ifdef SUMATOR_OVF_EN
  ,
  output logic             Ovf
`endif
);

  logic [NGROUPS-1:0] grp_g;
  logic [NGROUPS-1:0] grp_p;
  logic [NGROUPS-1:0] grp_c;
  word_t              sum_c;
  logic               c16;

  for (genvar i = 0; i < NGROUPS; i++) begin : g_grp
    cla_bloc_4b u_cla (
      .a   (A[i*GROUP +: GROUP]),
      .b   (B[i*GROUP +: GROUP]),
      .cin (grp_c[i]),
      .s   (sum_c[i*GROUP +: GROUP]),
      .G   (grp_g[i]),
      .P   (grp_p[i])
    );
  end

  // Second-level look-ahead: each group carry-in expands directly from C_in.
  assign grp_c[0] = C_in;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & C_in);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                  | (grp_p[1] & grp_p[0] & C_in);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                  | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & C_in);
  assign c16      = grp_g[3] | (grp_p[3] & grp_g[2])
                  | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & C_in);

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      Suma  <= '0;
      C_out <= 1'b0;
    end else begin
      Suma  <= sum_c;
      C_out <= c16;
    end
  end

`ifdef SUMATOR_OVF_EN
  logic c15;

  // Carry into bit 15 recovered from its sum bit: s15 = a15 ^ b15 ^ c15.
  assign c15 = sum_c[WIDTH-1] ^ A[WIDTH-1] ^ B[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) Ovf <= 1'b0;
    else     Ovf <= c16 ^ c15;
  end
`endif

endmodule : sumator_cal_16b

// File: tb/tb_sumator_cal_16b.sv
// Self-checking bench for sumator_cal_16b against an arithmetic reference.
module tb_sumator_cal_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        C_in;
  logic [15:0] Suma;
  logic        C_out;
`ifdef SUMATOR_OVF_EN
  logic        Ovf;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sumator_cal_16b dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .Suma  (Suma),
    .C_out (C_out)
`ifdef SUMATOR_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  // Reference: 17-bit unsigned sum; bit 16 is the carry-out.
  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
    int unsigned total;
    total = int'(a) + int'(b) + int'(cin);
    return total[16:0];
  endfunction

  // Reference: signed overflow when both operands share a sign the result lacks.
  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin);
    int sa, sb, total;
    sa = int'($signed(a));
    sb = int'($signed(b));
    total = sa + sb + int'(cin);
    return (total > 32767) || (total < -32768);
  endfunction

  // Apply inputs, advance one rising edge, settle before sampling.
  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic r);
    A = a; B = b; C_in = cin; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      tests_run++;
      if ({C_out, Suma} !== 17'h0_0000) begin
        tests_failed++;
        $display("FAIL reset_%0d: got C_out=%b Suma=%h, want C_out=0 Suma=0000", i, C_out, Suma);
      end
`ifdef SUMATOR_OVF_EN
      tests_run++;
      if (Ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_ovf_%0d: got Ovf=%b, want 0", i, Ovf);
      end
`endif
    end
  endtask

  // Directed vectors from the specification, checked one edge after issue.
  task automatic test_directed;
    logic [15:0] va [6] = '{16'h0010, 16'h0005, 16'hFFFF, 16'hFFFF, 16'h0FFF, 16'h7FFF};
    logic [15:0] vb [6] = '{16'h0002, 16'h0012, 16'h0001, 16'hFFFF, 16'h0000, 16'h0001};
    logic        vc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [16:0] want [6] = '{17'h0_0012, 17'h0_0018, 17'h1_0000,
                              17'h1_FFFF, 17'h0_1000, 17'h0_8000};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vc[i], 1'b0);
      tests_run++;
      if ({C_out, Suma} !== want[i]) begin
        tests_failed++;
        $display("FAIL directed_%0d: got {C_out,Suma}=%h, want %h", i, {C_out, Suma}, want[i]);
      end
`ifdef SUMATOR_OVF_EN
      tests_run++;
      if (Ovf !== (i == 5)) begin
        tests_failed++;
        $display("FAIL directed_ovf_%0d: got Ovf=%b, want %b", i, Ovf, (i == 5));
      end
`endif
    end
  endtask

  // Outputs must hold between edges even while inputs change.
  task automatic test_hold;
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    A = 16'hABCD; B = 16'h9876; C_in = 1'b1;
    #3;
    tests_run++;
    if ({C_out, Suma} !== 17'h0_3333) begin
      tests_failed++;
      $display("FAIL hold: got {C_out,Suma}=%h, want 03333", {C_out, Suma});
    end
  endtask

  task automatic test_reset_mid;
    drive(16'h1234, 16'h4321, 1'b0, 1'b1);
    tests_run++;
    if ({C_out, Suma} !== 17'h0_0000) begin
      tests_failed++;
      $display("FAIL reset_mid: got {C_out,Suma}=%h, want 00000", {C_out, Suma});
    end
    drive(16'h1234, 16'h4321, 1'b0, 1'b0);
    tests_run++;
    if ({C_out, Suma} !== 17'h0_5555) begin
      tests_failed++;
      $display("FAIL reset_release: got {C_out,Suma}=%h, want 05555", {C_out, Suma});
    end
  endtask

  // Back-to-back random vectors, one new operation every cycle.
  task automatic test_random;
    logic [15:0] a, b;
    logic        cin;
    logic [16:0] want;
    for (int i = 0; i < 10000; i++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      // Bias some vectors toward long carry chains.
      if (i % 8 == 0) b = ~a;
      drive(a, b, cin, 1'b0);
      want = ref_sum(a, b, cin);
      tests_run++;
      if ({C_out, Suma} !== want) begin
        tests_failed++;
        $display("FAIL random_%0d: A=%h B=%h C_in=%b got %h want %h", i, a, b, cin,
                 {C_out, Suma}, want);
      end
`ifdef SUMATOR_OVF_EN
      tests_run++;
      if (Ovf !== ref_ovf(a, b, cin)) begin
        tests_failed++;
        $display("FAIL random_ovf_%0d: A=%h B=%h C_in=%b got %b want %b", i, a, b, cin,
                 Ovf, ref_ovf(a, b, cin));
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; C_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sumator_cal_16b
